// File: rtl/dom_rand_source.sv
// dom_rand_source
// Fresh-randomness source for the 4-share DOM AND gadget. A 32-bit LFSR is
// loaded from an external seed and run through a warm-up phase. After that it
// advances by one RAND_W-bit word each time the consumer takes a word. Once
// RESEED_INTERVAL words have been consumed, a sticky reseed request is raised.
//
// Ports:
//   clock_0        sole clock, rising edge
//   reset_0        synchronous active-high reset
//   io_seed        32-bit seed value
//   io_seed_valid  seed offered this cycle
//   io_seed_ready  seed can be accepted this cycle (low only during warm-up)
//   io_rand_en     consumer takes the current word this cycle
//   io_rand        registered random word; bit k feeds p_rand_k of the gadget
//   io_rand_valid  io_rand holds post-warm-up randomness
//   io_reseed_req  consumed-word budget exhausted (sticky until next seed)

module dom_rand_source #(
   parameter int RAND_W          = 6,
   parameter int WARMUP_CYCLES   = 8,
   parameter int RESEED_INTERVAL = 1024
) (
   input  logic              clock_0,
   input  logic              reset_0,
   input  logic [31:0]       io_seed,
   input  logic              io_seed_valid,
   output logic              io_seed_ready,
   input  logic              io_rand_en,
   output logic [RAND_W-1:0] io_rand,
   output logic              io_rand_valid,
   output logic              io_reseed_req
);

   localparam int WARM_W = (WARMUP_CYCLES < 1) ? 1 : $clog2(WARMUP_CYCLES + 1);
   localparam int WORD_W = (RESEED_INTERVAL < 2) ? 1 : $clog2(RESEED_INTERVAL + 1);
   localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYCLES);
   localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(RESEED_INTERVAL);
   localparam logic [WORD_W-1:0] WORD_PRE  = WORD_W'(RESEED_INTERVAL - 1);

   typedef enum logic [1:0] {
      IDLE,
      WARMUP,
      RUN
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [31:0]       lfsr;
   logic [31:0]       lfsr_stepped;
   logic [RAND_W-1:0] word_bits;
   logic [WARM_W-1:0] warm_cnt;
   logic [WORD_W-1:0] word_cnt;
   logic              seed_take;
   logic              do_step;
   logic              warm_done;

   // One word step: RAND_W single LFSR steps chained in one cycle. The
   // feedback bit of step i becomes bit i of the new word.
   always_comb begin
      lfsr_stepped = lfsr;
      word_bits    = '0;
      for (int i = 0; i < RAND_W; i++) begin
         word_bits[i] = lfsr_stepped[31] ^ lfsr_stepped[21] ^ lfsr_stepped[1] ^ lfsr_stepped[0];
         lfsr_stepped = {lfsr_stepped[30:0], word_bits[i]};
      end
   end

   // Next-state and control decode. A seed is taken in IDLE or RUN only, and
   // a seed in RUN beats a simultaneous consumer enable. Warm-up steps every
   // cycle no matter what the consumer does.
   always_comb begin
      state_next    = state;
      io_seed_ready = (state != WARMUP);
      seed_take     = io_seed_valid & (state != WARMUP);
      do_step       = 1'b0;
      warm_done     = 1'b0;
      case (state)
         IDLE: begin
            if (seed_take) begin
               state_next = WARMUP;
            end
         end
         WARMUP: begin
            do_step = 1'b1;
            if (warm_cnt == WARM_LAST) begin
               warm_done  = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            if (seed_take) begin
               state_next = WARMUP;
            end else if (io_rand_en) begin
               do_step = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clock_0) begin
      if (reset_0) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Datapath registers. An all-zero seed is replaced by 1 because the LFSR
   // would otherwise be stuck at zero. The word counter saturates at the
   // interval, so the request stays up while output keeps flowing.
   always_ff @(posedge clock_0) begin
      if (reset_0) begin
         lfsr          <= '0;
         io_rand       <= '0;
         io_rand_valid <= 1'b0;
         io_reseed_req <= 1'b0;
         warm_cnt      <= '0;
         word_cnt      <= '0;
      end else if (seed_take) begin
         lfsr          <= (io_seed == 32'h0) ? 32'h0000_0001 : io_seed;
         io_rand_valid <= 1'b0;
         io_reseed_req <= 1'b0;
         warm_cnt      <= '0;
         word_cnt      <= '0;
      end else if (do_step) begin
         lfsr    <= lfsr_stepped;
         io_rand <= word_bits;
         if (state == WARMUP) begin
            if (warm_done) begin
               io_rand_valid <= 1'b1;
            end else begin
               warm_cnt <= warm_cnt + 1'b1;
            end
         end else if (word_cnt != WORD_LAST) begin
            word_cnt <= word_cnt + 1'b1;
            if (word_cnt == WORD_PRE) begin
               io_reseed_req <= 1'b1;
            end
         end
      end
   end

endmodule
